param_shift_register: RTL and testbench

PARAM_SHIFT_REGISTER -- requirements
Module: param_shift_register

---
 rtl/param_shift_register_pkg.sv | 26 ++
 rtl/param_shift_register_if.sv | 28 ++
 rtl/param_shift_register_shift_op.sv | 30 +++
 rtl/param_shift_register.sv | 81 ++++++++
 tb/tb_param_shift_register.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/param_shift_register_pkg.sv
// rtl/param_shift_register_pkg.sv - mode encodings and FSM state type for the shift register
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHR   = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_LOAD  = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_ROL   = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Only shift-type modes may be repeated as a burst.
    function automatic logic is_shift_mode(input mode_e m);
        return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
               (m == MODE_ROL) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/param_shift_register_if.sv
// rtl/param_shift_register_if.sv - control, data and status bundle of the shift register
interface param_shift_register_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] parallel_in;
    logic             serial_in_left;
    logic             serial_in_right;
    logic             start;
    logic [CNT_W-1:0] burst_cnt;
    logic [WIDTH-1:0] Q;
    logic             busy;
    logic             done;
    logic             serial_out_right;
    logic             serial_out_left;

    modport master (
        output en, mode, parallel_in, serial_in_left, serial_in_right, start, burst_cnt,
        input  Q, busy, done, serial_out_right, serial_out_left
    );

    modport slave (
        input  en, mode, parallel_in, serial_in_left, serial_in_right, start, burst_cnt,
        output Q, busy, done, serial_out_right, serial_out_left
    );
endinterface

// File: rtl/param_shift_register_shift_op.sv
// rtl/param_shift_register_shift_op.sv - combinational next-value function for every mode
module shift_op
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_e            mode,
    input  logic             serial_in_left,
    input  logic             serial_in_right,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (mode)
            MODE_HOLD:  q_next = q;
            MODE_SHR:   q_next = {serial_in_left, q[WIDTH-1:1]};
            MODE_SHL:   q_next = {q[WIDTH-2:0], serial_in_right};
            MODE_LOAD:  q_next = parallel_in;
            MODE_ROR:   q_next = {q[0], q[WIDTH-1:1]};
            MODE_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ASR:   q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_CLEAR: q_next = '0;
            default:    q_next = q;
        endcase
    end

endmodule

// File: rtl/param_shift_register.sv
// rtl/param_shift_register.sv - shift register with single-step and counted burst operation
module param_shift_register
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    param_shift_register_if.slave bus
);

    state_e           state;
    mode_e            cap_mode;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    mode_e            req_mode;
    mode_e            op_mode;
    logic             burst_req;

    assign req_mode  = mode_e'(bus.mode);
    assign burst_req = bus.start && is_shift_mode(req_mode);
    // Single-step and burst paths share one datapath; the burst uses the captured mode.
    assign op_mode   = (state == ST_BURST) ? cap_mode : req_mode;

    shift_op #(.WIDTH(WIDTH)) u_shift_op (
        .q               (q),
        .mode            (op_mode),
        .serial_in_left  (bus.serial_in_left),
        .serial_in_right (bus.serial_in_right),
        .parallel_in     (bus.parallel_in),
        .q_next          (q_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cap_mode <= MODE_HOLD;
            cnt      <= '0;
            q        <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (burst_req) begin
                        if (bus.burst_cnt != '0) begin
                            cap_mode <= req_mode;
                            cnt      <= bus.burst_cnt;
                            state    <= ST_BURST;
                            bus.busy <= 1'b1;
                        end else begin
                            bus.done <= 1'b1;
                        end
                    end else if (bus.en) begin
                        q <= q_next;
                    end
                end
                ST_BURST: begin
                    q <= q_next;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                    if (cnt <= 1) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.Q                = q;
    assign bus.serial_out_right = q[0];
    assign bus.serial_out_left  = q[WIDTH-1];

endmodule

// File: tb/tb_param_shift_register.sv
// tb/tb_param_shift_register.sv - directed self-checking bench for param_shift_register
module tb_param_shift_register;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    param_shift_register_if #(.WIDTH(8), .CNT_W(4)) bus ();

    param_shift_register #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [7:0] q, input logic b, input logic d);
        chk({tag, "_q"}, {24'd0, bus.Q}, {24'd0, q});
        chk({tag, "_busy"}, {31'd0, bus.busy}, {31'd0, b});
        chk({tag, "_done"}, {31'd0, bus.done}, {31'd0, d});
        chk({tag, "_excl"}, {31'd0, bus.busy & bus.done}, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.en = 1'b0;
        bus.mode = 3'b000;
        bus.parallel_in = 8'h00;
        bus.serial_in_left = 1'b0;
        bus.serial_in_right = 1'b0;
        bus.start = 1'b0;
        bus.burst_cnt = 4'd0;
        #2;
        chk_state("reset", 8'h00, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        step();

        // Parallel load, then hold with en=0
        bus.mode = 3'b011; bus.en = 1'b1; bus.parallel_in = 8'hA5;
        step();
        chk_state("load", 8'hA5, 1'b0, 1'b0);
        bus.en = 1'b0; bus.mode = 3'b001;
        step();
        chk_state("hold", 8'hA5, 1'b0, 1'b0);
        chk("sout_l", {31'd0, bus.serial_out_left}, 32'd1);
        chk("sout_r", {31'd0, bus.serial_out_right}, 32'd1);

        // Arithmetic shift right single step
        bus.mode = 3'b011; bus.en = 1'b1; bus.parallel_in = 8'h90;
        step();
        bus.mode = 3'b110;
        step();
        chk_state("asr", 8'hC8, 1'b0, 1'b0);

        // Rotate-left burst of 3; mode/en/parallel_in ignored while busy
        bus.mode = 3'b011; bus.parallel_in = 8'h81;
        step();
        bus.en = 1'b0; bus.start = 1'b1; bus.mode = 3'b101; bus.burst_cnt = 4'd3;
        step();
        chk_state("rol_k", 8'h81, 1'b1, 1'b0);
        bus.start = 1'b0; bus.mode = 3'b011; bus.en = 1'b1; bus.parallel_in = 8'hFF;
        step();
        chk_state("rol_1", 8'h03, 1'b1, 1'b0);
        step();
        chk_state("rol_2", 8'h06, 1'b1, 1'b0);
        step();
        chk_state("rol_3", 8'h0C, 1'b0, 1'b1);
        bus.en = 1'b0;
        step();
        chk_state("rol_after", 8'h0C, 1'b0, 1'b0);

        // Clear, then shift-right burst of 4 with start held while busy
        bus.mode = 3'b111; bus.en = 1'b1;
        step();
        chk_state("clear", 8'h00, 1'b0, 1'b0);
        bus.en = 1'b0; bus.start = 1'b1; bus.mode = 3'b001; bus.burst_cnt = 4'd4;
        bus.serial_in_left = 1'b1;
        step();
        chk_state("shr_k", 8'h00, 1'b1, 1'b0);
        step();
        chk_state("shr_1", 8'h80, 1'b1, 1'b0);
        step();
        chk_state("shr_2", 8'hC0, 1'b1, 1'b0);
        step();
        chk_state("shr_3", 8'hE0, 1'b1, 1'b0);
        step();
        chk_state("shr_4", 8'hF0, 1'b0, 1'b1);
        bus.start = 1'b0;
        step();
        chk_state("shr_after", 8'hF0, 1'b0, 1'b0);

        // Zero-count burst: done pulse only, no shift even with en=1
        bus.start = 1'b1; bus.mode = 3'b001; bus.burst_cnt = 4'd0; bus.en = 1'b1;
        step();
        chk_state("zero_k", 8'hF0, 1'b0, 1'b1);
        bus.start = 1'b0; bus.en = 1'b0;
        step();
        chk_state("zero_after", 8'hF0, 1'b0, 1'b0);

        // Start with a non-shift mode acts as a plain single step
        bus.start = 1'b1; bus.mode = 3'b011; bus.en = 1'b1; bus.parallel_in = 8'h3C;
        bus.burst_cnt = 4'd5;
        step();
        chk_state("nonshift", 8'h3C, 1'b0, 1'b0);
        bus.start = 1'b0;

        // Single-step shift left and rotate right
        bus.mode = 3'b010; bus.serial_in_right = 1'b1;
        step();
        chk_state("shl", 8'h79, 1'b0, 1'b0);
        bus.mode = 3'b100;
        step();
        chk_state("ror", 8'hBC, 1'b0, 1'b0);

        // Reset during an 8-step rotate-right burst
        bus.en = 1'b0; bus.start = 1'b1; bus.burst_cnt = 4'd8;
        step();
        chk_state("rst_k", 8'hBC, 1'b1, 1'b0);
        bus.start = 1'b0;
        step();
        chk_state("rst_1", 8'h5E, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_state("rst_async", 8'h00, 1'b0, 1'b0);
        step();
        chk_state("rst_held", 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        chk_state("rst_resume", 8'h00, 1'b0, 1'b0);
        bus.mode = 3'b011; bus.en = 1'b1; bus.parallel_in = 8'h5A;
        step();
        chk_state("rst_load", 8'h5A, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
